fp_result_packer: RTL and testbench

Output end of the floating-point multiplier datapath. Takes the raw product fields (sign, unnormalized biased exponent sum, 48-bit mantissa product, special-operand class) and packs them into an IEEE-754 single-precision word. It normalizes, rounds, and detects overflow and underflow. Two-stage pipeline with valid/ready handshakes on both sides. It is the encoder counterpart of the exponent-field special-value detection at the multiplier input.

---
 rtl/fp_result_packer_if.sv | 42 ++++
 rtl/fp_result_packer.sv | 178 +++++++++++++++++
 tb/tb_fp_result_packer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_result_packer_if.sv
// fp_result_packer_if: bundles the input-field and result handshakes of the
// floating-point result packer.
//
// Signals
//   in_valid / in_ready   : input fields offered / accepted
//   sign_in               : product sign
//   exp_sum    [9:0]      : two's-complement biased exponent sum
//   mant_prod  [47:0]     : raw 24x24 significand product
//   special_in [1:0]      : operand class (00 normal, 01 zero, 10 inf, 11 NaN)
//   out_valid / out_ready : result offered / taken
//   result     [31:0]     : packed binary32 word
//   overflow / underflow  : saturation / flush-to-zero flags
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may depend combinationally on the consumer side.
//
// Modports: master drives the input fields and out_ready (the datapath/bench
// side); slave is the packer itself.
interface fp_result_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_sum;
    logic [47:0] mant_prod;
    logic [1:0]  special_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, sign_in, exp_sum, mant_prod, special_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, sign_in, exp_sum, mant_prod, special_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_result_packer.sv
// fp_result_packer: final stage of the binary32 multiplier. Normalizes the raw
// significand product, rounds, handles special classes and exponent
// overflow/underflow, and packs an IEEE-754 single-precision word.
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; discards everything in flight
//   bus : fp_result_packer_if.slave (input fields, result, valid/ready pairs)
//
// Pipeline: stage 1 registers the normalized significand with guard/round/
// sticky; stage 2 registers the packed result, which drives the outputs
// directly. One item per cycle when unstalled; a stage advances when the
// stage after it is empty or is itself advancing.
//
// Configuration macro FP_ROUND_NEAREST_EN: when defined, round-to-nearest-even;
// when undefined, truncation (round toward zero).
module fp_result_packer (
    input logic             clk,
    input logic             rst,
    fp_result_packer_if.slave bus
);
    localparam logic [1:0] CLASS_NORMAL = 2'b00;
    localparam logic [1:0] CLASS_ZERO   = 2'b01;
    localparam logic [1:0] CLASS_INF    = 2'b10;
    localparam logic [1:0] CLASS_NAN    = 2'b11;

`ifdef FP_ROUND_NEAREST_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    // Stage 1 state
    logic        s1_valid;
    logic        s1_sign;
    logic [9:0]  s1_exp;
    logic [23:0] s1_sig;
    logic        s1_g;
    logic        s1_r;
    logic        s1_s;
    logic [1:0]  s1_class;

    // Stage 2 state (drives the outputs)
    logic        s2_valid;
    logic [31:0] s2_result;
    logic        s2_ovf;
    logic        s2_unf;

    logic        s2_advance;
    logic        s1_advance;
    logic        in_accept;

    assign s2_advance   = s2_valid & bus.out_ready;
    assign s1_advance   = s1_valid & (!s2_valid | s2_advance);
    assign bus.in_ready = !s1_valid | s1_advance;
    assign in_accept    = bus.in_valid & bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.overflow  = s2_ovf;
    assign bus.underflow = s2_unf;

    // Normalize: the product of two [1,2) significands lies in [1,4), so at
    // most a single right shift is needed. Sticky absorbs the shifted-out bit.
    logic [9:0]  norm_exp;
    logic [23:0] norm_sig;
    logic        norm_g;
    logic        norm_r;
    logic        norm_s;

    always_comb begin
        norm_exp = bus.exp_sum;
        norm_sig = bus.mant_prod[46:23];
        norm_g   = bus.mant_prod[22];
        norm_r   = bus.mant_prod[21];
        norm_s   = |bus.mant_prod[20:0];
        if (bus.mant_prod[47]) begin
            norm_exp = bus.exp_sum + 10'd1;
            norm_sig = bus.mant_prod[47:24];
            norm_g   = bus.mant_prod[23];
            norm_r   = bus.mant_prod[22];
            norm_s   = |bus.mant_prod[21:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= 10'd0;
            s1_sig   <= 24'd0;
            s1_g     <= 1'b0;
            s1_r     <= 1'b0;
            s1_s     <= 1'b0;
            s1_class <= CLASS_NORMAL;
        end else if (in_accept) begin
            s1_valid <= 1'b1;
            s1_sign  <= bus.sign_in;
            s1_exp   <= norm_exp;
            s1_sig   <= norm_sig;
            s1_g     <= norm_g;
            s1_r     <= norm_r;
            s1_s     <= norm_s;
            s1_class <= bus.special_in;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Round: the increment is added to the fraction only. A carry into the
    // hidden-bit position with the hidden bit already set means the whole
    // 24-bit significand overflowed; the fraction is then all zeros and the
    // exponent moves up by one.
    logic        round_inc;
    logic [23:0] frac_sum;
    logic        sig_carry;
    logic [9:0]  final_exp;
    logic [22:0] final_frac;

    always_comb begin
        round_inc  = ROUND_EN & s1_g & (s1_r | s1_s | s1_sig[0]);
        frac_sum   = {1'b0, s1_sig[22:0]} + {23'd0, round_inc};
        sig_carry  = s1_sig[23] & frac_sum[23];
        final_exp  = s1_exp + {9'd0, sig_carry};
        final_frac = frac_sum[22:0];
    end

    // Pack in priority order: class first, then exponent range.
    logic [31:0] pack_result;
    logic        pack_ovf;
    logic        pack_unf;

    always_comb begin
        pack_result = {s1_sign, 31'd0};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        case (s1_class)
            CLASS_NAN: begin
                pack_result = 32'h7FC0_0000;
            end
            CLASS_INF: begin
                pack_result = {s1_sign, 8'hFF, 23'd0};
                pack_ovf    = 1'b1;
            end
            CLASS_ZERO: begin
                pack_result = {s1_sign, 31'd0};
            end
            CLASS_NORMAL: begin
                if ($signed(final_exp) >= 10'sd255) begin
                    pack_result = {s1_sign, 8'hFF, 23'd0};
                    pack_ovf    = 1'b1;
                end else if ($signed(final_exp) <= 10'sd0) begin
                    pack_result = {s1_sign, 31'd0};
                    pack_unf    = 1'b1;
                end else begin
                    pack_result = {s1_sign, final_exp[7:0], final_frac};
                end
            end
        endcase
    end

    // Output register only loads on advance, so the result holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= 32'd0;
            s2_ovf    <= 1'b0;
            s2_unf    <= 1'b0;
        end else if (s1_advance) begin
            s2_valid  <= 1'b1;
            s2_result <= pack_result;
            s2_ovf    <= pack_ovf;
            s2_unf    <= pack_unf;
        end else if (s2_advance) begin
            s2_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_result_packer.sv
// tb_fp_result_packer: directed-vector bench for fp_result_packer. Expected
// words are hand-computed constants pushed into a queue at issue time; a
// monitor pops and compares each result as it is taken.
module tb_fp_result_packer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_result_packer_if bus();

    fp_result_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected entry layout: {overflow, underflow, result}
    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;
    int total = 0;
    int bad   = 0;

`ifdef FP_ROUND_NEAREST_EN
    localparam logic [31:0] RC_EXP      = 32'h4000_0000;
    localparam logic [31:0] TIE_ODD_EXP = 32'h3F80_0002;
    localparam logic [33:0] RC_OVF_EXP  = {1'b1, 1'b0, 32'h7F80_0000};
`else
    localparam logic [31:0] RC_EXP      = 32'h3FFF_FFFF;
    localparam logic [31:0] TIE_ODD_EXP = 32'h3F80_0001;
    localparam logic [33:0] RC_OVF_EXP  = {1'b0, 1'b0, 32'h7F7F_FFFF};
`endif

    function automatic logic [33:0] ex(input logic [31:0] r, input logic o, input logic u);
        return {o, u, r};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and
    // ready are both high at the falling edge (inputs only move at posedge+1).
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h want no output", bus.result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", {bus.overflow, bus.underflow, bus.result}, mon_exp);
            end
        end
    end

    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [1:0] c, input logic [33:0] x);
        int n;
        exp_q.push_back(x);
        bus.in_valid   = 1'b1;
        bus.sign_in    = s;
        bus.exp_sum    = e;
        bus.mant_prod  = m;
        bus.special_in = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors();
        send(1'b0, 10'd128, 48'h6000_0000_0000, 2'b00, ex(32'h4040_0000, 1'b0, 1'b0));
        send(1'b1, 10'd254, 48'h8000_0000_0000, 2'b00, ex(32'hFF80_0000, 1'b1, 1'b0));
        send(1'b0, 10'd127, 48'h7FFF_FF80_0000, 2'b00, ex(32'h3FFF_FFFF, 1'b0, 1'b0));
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00, ex(RC_EXP, 1'b0, 1'b0));
        send(1'b1, 10'd0,   48'h4000_0000_0000, 2'b00, ex(32'h8000_0000, 1'b0, 1'b1));
        send(1'b1, 10'd5,   48'h4000_0000_0000, 2'b11, ex(32'h7FC0_0000, 1'b0, 1'b0));
        send(1'b0, 10'd5,   48'h4000_0000_0000, 2'b10, ex(32'h7F80_0000, 1'b1, 1'b0));
        send(1'b1, 10'd5,   48'h4000_0000_0000, 2'b01, ex(32'h8000_0000, 1'b0, 1'b0));
        send(1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, ex(32'h3F80_0000, 1'b0, 1'b0));
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, ex(TIE_ODD_EXP, 1'b0, 1'b0));
        send(1'b0, 10'd1,   48'h4000_0000_0000, 2'b00, ex(32'h0080_0000, 1'b0, 1'b0));
        send(1'b0, 10'd255, 48'h4000_0000_0000, 2'b00, ex(32'h7F80_0000, 1'b1, 1'b0));
        send(1'b0, 10'd254, 48'h4000_0000_0000, 2'b00, ex(32'h7F00_0000, 1'b0, 1'b0));
        send(1'b1, 10'h3FB, 48'h8000_0000_0000, 2'b00, ex(32'h8000_0000, 1'b0, 1'b1));
        send(1'b1, 10'd126, 48'h8000_0000_0001, 2'b00, ex(32'hBF80_0000, 1'b0, 1'b0));
        send(1'b0, 10'd254, 48'h7FFF_FFC0_0000, 2'b00, RC_OVF_EXP);
    endtask

    logic [33:0] held;
    logic [15:0] ready_pat;

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.sign_in    = 1'b0;
        bus.exp_sum    = 10'd0;
        bus.mant_prod  = 48'd0;
        bus.special_in = 2'b00;
        bus.out_ready  = 1'b1;
        ready_pat      = 16'b1011_0010_1110_0110;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {33'd0, bus.out_valid}, 34'd0);
        check("reset_result", {2'b00, bus.result}, 34'd0);
        check("reset_flags", {32'd0, bus.overflow, bus.underflow}, 34'd0);
        check("reset_in_ready", {33'd0, bus.in_ready}, 34'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back stream with the consumer always ready
        run_vectors();
        drain();

        // Same stream under an irregular out_ready pattern
        fork
            run_vectors();
            begin
                for (int i = 0; i < 48; i++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ready_pat[i % 16];
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Backpressure: four items with the consumer stalled
        bus.out_ready = 1'b0;
        fork
            begin
                send(1'b0, 10'd128, 48'h6000_0000_0000, 2'b00, ex(32'h4040_0000, 1'b0, 1'b0));
                send(1'b0, 10'd127, 48'h4000_0000_0000, 2'b00, ex(32'h3F80_0000, 1'b0, 1'b0));
                send(1'b1, 10'd128, 48'h4000_0000_0000, 2'b00, ex(32'hC000_0000, 1'b0, 1'b0));
                send(1'b0, 10'd129, 48'h8000_0000_0000, 2'b00, ex(32'h4100_0000, 1'b0, 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", {33'd0, bus.in_ready}, 34'd0);
                check("bp_out_valid", {33'd0, bus.out_valid}, 34'd1);
                held = {bus.overflow, bus.underflow, bus.result};
                check("bp_head_value", held, ex(32'h4040_0000, 1'b0, 1'b0));
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold", {bus.overflow, bus.underflow, bus.result}, held);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two items in flight
        bus.out_ready = 1'b0;
        send(1'b0, 10'd128, 48'h6000_0000_0000, 2'b00, ex(32'h4040_0000, 1'b0, 1'b0));
        send(1'b0, 10'd127, 48'h4000_0000_0000, 2'b00, ex(32'h3F80_0000, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", {33'd0, bus.out_valid}, 34'd0);
        check("rst_async_result", {2'b00, bus.result}, 34'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_stale", {33'd0, bus.out_valid}, 34'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 10'd128, 48'h6000_0000_0000, 2'b00, ex(32'hC040_0000, 1'b0, 1'b0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
